// File: rtl/regfile_mp.sv
// Multi-port register file: one byte-masked write port, two combinational read ports.
// Entry 0 reads as zero. After reset the array is zeroed one entry per cycle before writes are accepted.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [ADDR_W-1:0]     wR,
    input  logic [DATA_W-1:0]     wD,
    input  logic [ADDR_W-1:0]     rR1,
    input  logic [ADDR_W-1:0]     rR2,
    output logic [DATA_W-1:0]     rD1,
    output logic [DATA_W-1:0]     rD2,
    output logic                  ready,
    output logic                  wr_drop
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic BYP_EN = (BYPASS != 32'sd0);
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   clr_idx_r;
    logic [ADDR_W-1:0]   clr_idx_nxt_s;
    logic                wr_drop_r;
    logic                drop_s;
    logic                wr_en_s;
    logic                rd_ok_s;
    logic                hit1_s;
    logic                hit2_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Stored word with the enabled bytes of the incoming write laid over it.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Clear sweep: walk clr_idx from 1 to DEPTH-1, then settle in READY.
    always_comb begin
        state_nxt_s   = state_r;
        clr_idx_nxt_s = clr_idx_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_idx_r == IDX_LAST) begin
                    state_nxt_s   = ST_READY;
                    clr_idx_nxt_s = IDX_ONE;
                end else begin
                    clr_idx_nxt_s = clr_idx_r + IDX_ONE;
                end
            end
            ST_READY: begin
                state_nxt_s = ST_READY;
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_idx_nxt_s = IDX_ONE;
            end
        endcase
    end

    // Write qualification; address 0 and empty byte masks are silently ignored.
    always_comb begin
        wr_en_s = rst_n && (state_r == ST_READY) && we && (wR != IDX_ZERO);
        drop_s  = (state_r == ST_CLEAR) && we && (|wbe) && (wR != IDX_ZERO);
        rd_ok_s = rst_n && (state_r == ST_READY);
        hit1_s  = BYP_EN && wr_en_s && (wR == rR1);
        hit2_s  = BYP_EN && wr_en_s && (wR == rR2);
    end

    // Control state; the reset restarts the whole clear sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= IDX_ONE;
            wr_drop_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            clr_idx_r <= clr_idx_nxt_s;
            wr_drop_r <= drop_s;
        end
    end

    // Storage array: zeroed by the sweep, otherwise byte-masked writes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clr_idx_r] <= WORD_ZERO;
            end else if (wr_en_s) begin
                for (int i = 0; i < NB; i++) begin
                    if (wbe[i]) begin
                        mem_r[wR][8*i +: 8] <= wD[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read ports; both ports use identical logic so equal addresses give equal data.
    always_comb begin
        if (!rd_ok_s || (rR1 == IDX_ZERO)) begin
            rD1 = WORD_ZERO;
        end else if (hit1_s) begin
            rD1 = merge_bytes(mem_r[rR1], wD, wbe);
        end else begin
            rD1 = mem_r[rR1];
        end
        if (!rd_ok_s || (rR2 == IDX_ZERO)) begin
            rD2 = WORD_ZERO;
        end else if (hit2_s) begin
            rD2 = merge_bytes(mem_r[rR2], wD, wbe);
        end else begin
            rD2 = mem_r[rR2];
        end
    end

    assign ready   = rst_n && (state_r == ST_READY);
    assign wr_drop = wr_drop_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default, no-bypass and 16-bit/8-entry instances.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n, we;
    logic [3:0]  wbe;
    logic [4:0]  wR, rR1, rR2;
    logic [31:0] wD, rD1, rD2, nb_rD1, nb_rD2;
    logic        ready, wr_drop, nb_ready, nb_wr_drop;
    logic        s_rst_n, s_we, s_ready, s_wr_drop;
    logic [1:0]  s_wbe;
    logic [2:0]  s_wR, s_rR1, s_rR2;
    logic [15:0] s_wD, s_rD1, s_rD2;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .wR(wR), .wD(wD),
        .rR1(rR1), .rR2(rR2), .rD1(rD1), .rD2(rD2), .ready(ready), .wr_drop(wr_drop)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .wbe(wbe), .wR(wR), .wD(wD),
        .rR1(rR1), .rR2(rR2), .rD1(nb_rD1), .rD2(nb_rD2), .ready(nb_ready), .wr_drop(nb_wr_drop)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3)) dut_s (
        .clk(clk), .rst_n(s_rst_n), .we(s_we), .wbe(s_wbe), .wR(s_wR), .wD(s_wD),
        .rR1(s_rR1), .rR2(s_rR2), .rD1(s_rD1), .rD2(s_rD2), .ready(s_ready), .wr_drop(s_wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic check_now(input logic [31:0] got, input logic [31:0] exp, input string nm);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic wait_ready(input int max_cyc, input string nm);
        int n;
        n = 0;
        while ((ready !== 1'b1) && (n < max_cyc)) begin
            tick();
            n++;
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL %s: ready not seen within %0d cycles", nm, max_cyc);
        end
    endtask

    // Monitor: observe outputs mid-cycle and retire every queued expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                0:       got = rD1;
                1:       got = rD2;
                2:       got = {31'd0, ready};
                3:       got = {31'd0, wr_drop};
                4:       got = nb_rD1;
                5:       got = nb_rD2;
                6:       got = {31'd0, nb_ready};
                7:       got = {16'd0, s_rD1};
                8:       got = {31'd0, s_ready};
                9:       got = {31'd0, nb_wr_drop};
                10:      got = {16'd0, s_rD2};
                11:      got = {31'd0, s_wr_drop};
                default: got = 32'hxxxx_xxxx;
            endcase
            total++;
            if (got !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h required %h", e.name, got, e.exp);
            end
        end
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; wbe = 4'h0; wR = 5'd0; wD = 32'd0; rR1 = 5'd0; rR2 = 5'd0;
        s_rst_n = 1'b0; s_we = 1'b0; s_wbe = 2'b00; s_wR = 3'd0; s_wD = 16'd0; s_rR1 = 3'd0; s_rR2 = 3'd0;

        // Reset held low: outputs forced, writes ignored without a drop pulse.
        tick();
        check_now({31'd0, ready}, 32'd0, "rst_ready_now");
        check_now({31'd0, wr_drop}, 32'd0, "rst_wr_drop_now");
        check_now(rD1, 32'd0, "rst_rd1_now");
        we = 1'b1; wR = 5'd3; wD = 32'hCAFEF00D; wbe = 4'hF; rR1 = 5'd3;
        push(2, 32'd0, "rst_ready"); push(0, 32'd0, "rst_rd1");
        push(6, 32'd0, "rst_nb_ready"); push(8, 32'd0, "rst_s_ready");
        tick();
        push(3, 32'd0, "rst_wr_drop");
        rst_n = 1'b1; s_rst_n = 1'b1; we = 1'b0;

        // Clear sweep: ready after the 31st edge (7th for the small instance).
        for (int k = 1; k <= 31; k++) begin
            tick();
            rR1 = 5'(k); rR2 = 5'(k);
            push(2, (k == 31) ? 32'd1 : 32'd0, "clr_ready");
            push(0, 32'd0, "clr_rd1");
            if (k <= 8) push(8, (k >= 7) ? 32'd1 : 32'd0, "s_clr_ready");
        end

        for (int a = 0; a < 32; a++) begin
            tick();
            rR1 = 5'(a); rR2 = 5'(31 - a);
            push(0, 32'd0, "init_rd1"); push(1, 32'd0, "init_rd2");
        end

        // Byte-enable merge, including forwarding of the merged word.
        tick();
        we = 1'b1; wR = 5'd5; wD = 32'hDEADBEEF; wbe = 4'hF; rR1 = 5'd9; rR2 = 5'd9;
        push(0, 32'd0, "other_rd1");
        tick();
        wD = 32'h11223344; wbe = 4'b0101; rR1 = 5'd5; rR2 = 5'd5;
        push(0, 32'hDE22BE44, "byp_merge_rd1"); push(1, 32'hDE22BE44, "byp_merge_rd2");
        push(4, 32'hDEADBEEF, "nb_old_rd1");
        tick();
        we = 1'b0;
        push(0, 32'hDE22BE44, "merge_rd1"); push(4, 32'hDE22BE44, "nb_merge_rd1");

        // Same-cycle forwarding on both ports vs. no forwarding.
        tick();
        we = 1'b1; wR = 5'd7; wD = 32'hA5A5A5A5; wbe = 4'hF; rR1 = 5'd7; rR2 = 5'd7;
        push(0, 32'hA5A5A5A5, "byp_rd1"); push(1, 32'hA5A5A5A5, "byp_rd2");
        push(4, 32'd0, "nb_byp_rd1"); push(5, 32'd0, "nb_byp_rd2");
        tick();
        we = 1'b0;
        push(0, 32'hA5A5A5A5, "wr7_rd1"); push(5, 32'hA5A5A5A5, "nb_wr7_rd2");

        // Empty byte mask: no change, no drop.
        tick();
        we = 1'b1; wD = 32'd0; wbe = 4'h0;
        push(0, 32'hA5A5A5A5, "wbe0_byp");
        tick();
        we = 1'b0;
        push(0, 32'hA5A5A5A5, "wbe0_rd1"); push(3, 32'd0, "wbe0_drop");

        // Entry 0 stays zero.
        tick();
        we = 1'b1; wR = 5'd0; wD = 32'hFFFFFFFF; wbe = 4'hF; rR1 = 5'd0; rR2 = 5'd0;
        push(0, 32'd0, "r0_byp_rd1"); push(1, 32'd0, "r0_byp_rd2");
        tick();
        we = 1'b0;
        push(0, 32'd0, "r0_rd1"); push(3, 32'd0, "r0_drop"); push(9, 32'd0, "nb_r0_drop");

        // Mid-READY reset wipes contents; writes during clear are dropped.
        tick();
        we = 1'b1; wR = 5'd3; wD = 32'h12345678; wbe = 4'hF; rR1 = 5'd3; rR2 = 5'd5;
        tick();
        we = 1'b0;
        push(0, 32'h12345678, "e3_rd1"); push(1, 32'hDE22BE44, "e5_rd2");
        tick();
        rst_n = 1'b0;
        push(2, 32'd0, "midrst_ready"); push(0, 32'd0, "midrst_rd1"); push(6, 32'd0, "midrst_nb_ready");
        tick();
        rst_n = 1'b1; we = 1'b1; wR = 5'd3; wD = 32'hFFFFFFFF; wbe = 4'hF;
        push(2, 32'd0, "reclr_ready0"); push(0, 32'd0, "reclr_rd1");
        tick();
        we = 1'b0;
        push(3, 32'd1, "clr_drop"); push(9, 32'd1, "nb_clr_drop");
        tick();
        push(3, 32'd0, "clr_drop_pulse");
        for (int k = 3; k <= 31; k++) begin
            tick();
            push(2, (k == 31) ? 32'd1 : 32'd0, "reclr_ready");
        end
        wait_ready(4, "reclr_wait_ready");
        rR1 = 5'd3; rR2 = 5'd5;
        push(0, 32'd0, "e3_cleared"); push(1, 32'd0, "e5_cleared"); push(4, 32'd0, "nb_e3_cleared");

        // Small instance: upper-byte-only write to the last entry.
        tick();
        s_we = 1'b1; s_wR = 3'd7; s_wD = 16'hBEEF; s_wbe = 2'b10; s_rR1 = 3'd7; s_rR2 = 3'd7;
        push(7, 32'h0000BE00, "s_byp_rd1");
        tick();
        s_we = 1'b0;
        push(7, 32'h0000BE00, "s_rd1"); push(10, 32'h0000BE00, "s_rd2"); push(11, 32'd0, "s_drop");

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
